mips_memio: RTL and testbench

- Data-side memory/IO mapper that sits directly downstream of the mips core.
- Consumes the core's mem_addr, mem_wr and mem_writedata, and returns mem_readdata combinationally in the same cycle, as the single-cycle core requires.
- Contains the data RAM, an LED register, a prescaled free-running timer, and a 4-entry character FIFO drained by a ready/valid display port.

---
 rtl/mips_memio.sv | 184 ++++++++++++++++++
 tb/tb_mips_memio.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_memio.sv
// Data-side memory/IO mapper for the single-cycle mips core: data RAM, LED, prescaled timer, character FIFO.
// Optional timer compare/match block is enabled by defining MIPS_MEMIO_TIMER_CMP_EN.
module mips_memio #(
    parameter int Dbits    = 32,
    parameter int Nloc     = 64,
    parameter int PRESCALE = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [31:0]      mem_addr,
    input  logic             mem_wr,
    input  logic [Dbits-1:0] mem_writedata,
    output logic [Dbits-1:0] mem_readdata,
    output logic [15:0]      led,
    output logic             chr_valid,
    output logic [7:0]       chr_data,
    input  logic             chr_ready
);

    localparam int AW = $clog2(Nloc);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [31:0] RAM_BASE   = 32'h1001_0000;
    localparam logic [31:0] LED_ADDR   = 32'h1003_0000;
    localparam logic [31:0] TIMER_ADDR = 32'h1003_0004;
    localparam logic [31:0] CHR_ADDR   = 32'h1003_0008;
`ifdef MIPS_MEMIO_TIMER_CMP_EN
    localparam logic [31:0] CMP_ADDR   = 32'h1003_000C;
    localparam logic [31:0] FLAG_ADDR  = 32'h1003_0010;
`endif

    logic [31:0]      word_addr;
    logic             ram_hit;
    logic [AW-1:0]    ram_idx;
    logic             we;
    logic             wr_led;
    logic             wr_timer;
    logic             wr_chr;
    logic [1:0]       unused_addr_bits;

    assign word_addr        = {mem_addr[31:2], 2'b00};
    assign unused_addr_bits = mem_addr[1:0];
    assign ram_hit          = (word_addr[31:AW+2] == RAM_BASE[31:AW+2]);
    assign ram_idx          = mem_addr[AW+1:2];
    assign we               = mem_wr && enable;
    assign wr_led           = we && (word_addr == LED_ADDR);
    assign wr_timer         = we && (word_addr == TIMER_ADDR);
    assign wr_chr           = we && (word_addr == CHR_ADDR);

    // Data RAM: no reset, contents undefined until written.
    logic [Dbits-1:0] ram [Nloc];

    always_ff @(posedge clk) begin
        if (we && ram_hit)
            ram[ram_idx] <= mem_writedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            led <= 16'h0000;
        else if (wr_led)
            led <= mem_writedata[15:0];
    end

    // Timer: a CPU write overrides the tick and restarts the prescaler.
    logic [PW-1:0] presc;
    logic [31:0]   timer;
    logic          tick;

    assign tick = enable && (presc == PW'(PRESCALE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            timer <= 32'h0;
        end else if (wr_timer) begin
            presc <= '0;
            timer <= mem_writedata[31:0];
        end else if (tick) begin
            presc <= '0;
            timer <= timer + 32'd1;
        end else if (enable) begin
            presc <= presc + PW'(1);
        end
    end

    // Character FIFO. Handshake: chr_valid/chr_data describe the head entry;
    // the head is consumed on any clock edge where chr_valid && chr_ready,
    // regardless of enable. A pop and a push may share an edge, even when full.
    logic [7:0] fifo_mem [4];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [2:0] count;
    logic       overflow;
    logic       full;
    logic       empty;
    logic       pop;
    logic       push_req;
    logic       push;
    logic       ovf_clr;

    assign full      = (count == 3'd4);
    assign empty     = (count == 3'd0);
    assign chr_valid = !empty;
    assign chr_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
    assign pop       = chr_valid && chr_ready;
    assign push_req  = wr_chr && !mem_writedata[31];
    assign ovf_clr   = wr_chr && mem_writedata[31];
    assign push      = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= mem_writedata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            count    <= 3'd0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (ovf_clr)
                overflow <= 1'b0;
            else if (push_req && !push)
                overflow <= 1'b1;
        end
    end

`ifdef MIPS_MEMIO_TIMER_CMP_EN
    logic [31:0] cmp;
    logic        match;
    logic        match_set;
    logic        wr_cmp;
    logic        wr_flag;

    assign wr_cmp    = we && (word_addr == CMP_ADDR);
    assign wr_flag   = we && (word_addr == FLAG_ADDR);
    assign match_set = tick && !wr_timer && ((timer + 32'd1) == cmp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp   <= 32'h0;
            match <= 1'b0;
        end else begin
            if (wr_cmp)
                cmp <= mem_writedata[31:0];
            if (match_set)
                match <= 1'b1;
            else if (wr_flag)
                match <= 1'b0;
        end
    end
`endif

    logic [31:0] reg_word;

    always_comb begin
        reg_word = 32'h0;
        case (word_addr)
            LED_ADDR:   reg_word = {16'h0000, led};
            TIMER_ADDR: reg_word = timer;
            CHR_ADDR:   reg_word = {29'h0, full, empty, overflow};
`ifdef MIPS_MEMIO_TIMER_CMP_EN
            CMP_ADDR:   reg_word = cmp;
            FLAG_ADDR:  reg_word = {31'h0, match};
`endif
            default:    reg_word = 32'h0;
        endcase
    end

    assign mem_readdata = ram_hit ? ram[ram_idx] : Dbits'(reg_word);

endmodule

// File: tb/tb_mips_memio.sv
// Directed bench for mips_memio (PRESCALE=4): RAM, LED, timer, character FIFO, async reset,
// and the compare/match block when MIPS_MEMIO_TIMER_CMP_EN is defined.
module tb_mips_memio;

    localparam logic [31:0] LED_A   = 32'h1003_0000;
    localparam logic [31:0] TIMER_A = 32'h1003_0004;
    localparam logic [31:0] CHR_A   = 32'h1003_0008;
    localparam logic [31:0] CMP_A   = 32'h1003_000C;
    localparam logic [31:0] FLAG_A  = 32'h1003_0010;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic [15:0] led;
    logic        chr_valid;
    logic [7:0]  chr_data;
    logic        chr_ready;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_c;

    mips_memio #(.Dbits(32), .Nloc(64), .PRESCALE(4)) dut (
        .clk(clk), .reset(rst), .enable(enable),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .led(led),
        .chr_valid(chr_valid), .chr_data(chr_data), .chr_ready(chr_ready)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks: all are entered and left at a falling edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_addr = a;
        mem_wr = 1'b1;
        mem_writedata = d;
        @(negedge clk);
        mem_wr = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        mem_addr = a;
        #1;
        check(tag, mem_readdata, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        chr_ready = 1'b1;
        while (exp_q.size() > 0) begin
            exp_c = exp_q.pop_front();
            #1;
            check({tag, "_valid"}, {31'h0, chr_valid}, 32'h1);
            check({tag, "_data"}, {24'h0, chr_data}, {24'h0, exp_c});
            @(negedge clk);
        end
        #1;
        check({tag, "_empty"}, {31'h0, chr_valid}, 32'h0);
        chr_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        mem_addr = 32'h0;
        mem_wr = 1'b0;
        mem_writedata = 32'h0;
        chr_ready = 1'b0;
        idle(3);
        rst = 1'b0;

        // Reset state
        #1;
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_valid", {31'h0, chr_valid}, 32'h0);
        check("rst_chr_data", {24'h0, chr_data}, 32'h0);
        rd("rst_timer", TIMER_A, 32'h0);
        rd("rst_status", CHR_A, 32'h2);

        // RAM and decode
        enable = 1'b1;
        wr(32'h1001_0010, 32'hDEAD_BEEF);
        rd("ram_rd", 32'h1001_0010, 32'hDEAD_BEEF);
        rd("ram_rd_unaligned", 32'h1001_0013, 32'hDEAD_BEEF);
        rd("unmapped", 32'h1002_0000, 32'h0);
        wr(32'h1001_00FC, 32'h1234_5678);
        rd("ram_last", 32'h1001_00FC, 32'h1234_5678);
        wr(32'h1001_0100, 32'hCAFE_F00D);
        rd("ram_past_end", 32'h1001_0100, 32'h0);

        // LED, including a write with enable low
        wr(LED_A, 32'h1234_ABCD);
        rd("led_rd", LED_A, 32'h0000_ABCD);
        check("led_port", {16'h0, led}, 32'h0000_ABCD);
        enable = 1'b0;
        wr(LED_A, 32'h0000_5555);
        rd("led_no_enable", LED_A, 32'h0000_ABCD);
        enable = 1'b1;

        // Timer: 12 enabled cycles at PRESCALE=4 give 3 ticks
        wr(TIMER_A, 32'h0);
        idle(12);
        rd("timer_12", TIMER_A, 32'h3);
        enable = 1'b0;
        idle(5);
        rd("timer_hold", TIMER_A, 32'h3);
        enable = 1'b1;
        wr(TIMER_A, 32'hFFFF_FFFF);
        rd("timer_wr", TIMER_A, 32'hFFFF_FFFF);
        idle(4);
        rd("timer_wrap", TIMER_A, 32'h0);

        // FIFO overflow then drain
        wr(CHR_A, 32'h41); exp_q.push_back(8'h41);
        wr(CHR_A, 32'h42); exp_q.push_back(8'h42);
        wr(CHR_A, 32'h43); exp_q.push_back(8'h43);
        wr(CHR_A, 32'h44); exp_q.push_back(8'h44);
        wr(CHR_A, 32'h45);
        rd("status_full_ovf", CHR_A, 32'h5);
        drain("drain1");
        rd("status_empty_ovf", CHR_A, 32'h3);
        wr(CHR_A, 32'h8000_0000);
        rd("status_ovf_clr", CHR_A, 32'h2);
        check("ovf_clr_no_push", {31'h0, chr_valid}, 32'h0);

        // Full FIFO with simultaneous pop and push
        wr(CHR_A, 32'h61); exp_q.push_back(8'h61);
        wr(CHR_A, 32'h62); exp_q.push_back(8'h62);
        wr(CHR_A, 32'h63); exp_q.push_back(8'h63);
        wr(CHR_A, 32'h64); exp_q.push_back(8'h64);
        rd("status_full", CHR_A, 32'h4);
        chr_ready = 1'b1;
        exp_c = exp_q.pop_front();
        #1;
        check("simul_head", {24'h0, chr_data}, {24'h0, exp_c});
        exp_q.push_back(8'h65);
        wr(CHR_A, 32'h65);
        chr_ready = 1'b0;
        rd("status_simul", CHR_A, 32'h4);
        drain("drain2");

        // Asynchronous reset mid-stream
        wr(CHR_A, 32'h78);
        wr(CHR_A, 32'h79);
        wr(LED_A, 32'h0000_00A5);
        check("pre_rst_led", {16'h0, led}, 32'h0000_00A5);
        check("pre_rst_valid", {31'h0, chr_valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'h0, chr_valid}, 32'h0);
        check("async_rst_led", {16'h0, led}, 32'h0);
        rd("async_rst_status", CHR_A, 32'h2);
        @(negedge clk);
        rst = 1'b0;

`ifdef MIPS_MEMIO_TIMER_CMP_EN
        // Compare/match: timer reaches 2 after 1 + 7 enabled edges
        rd("cmp_rst", CMP_A, 32'h0);
        wr(TIMER_A, 32'h0);
        wr(CMP_A, 32'h2);
        rd("cmp_rd", CMP_A, 32'h2);
        rd("flag_clear0", FLAG_A, 32'h0);
        idle(6);
        rd("timer_pre_match", TIMER_A, 32'h1);
        rd("flag_pre_match", FLAG_A, 32'h0);
        idle(1);
        rd("timer_match", TIMER_A, 32'h2);
        rd("flag_set", FLAG_A, 32'h1);
        idle(4);
        rd("flag_sticky", FLAG_A, 32'h1);
        wr(FLAG_A, 32'h0);
        rd("flag_cleared", FLAG_A, 32'h0);
`else
        wr(CMP_A, 32'h5);
        rd("cmp_absent", CMP_A, 32'h0);
        rd("flag_absent", FLAG_A, 32'h0);
`endif

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
